pixel_stream_receiver: RTL

// Sink end of the pixel stream protocol: colour + first/last_x/last_y flags + valid/ready.

---
 rtl/pixel_stream_pkg.sv | 23 ++
 rtl/pixel_stream_receiver_skid.sv | 63 ++++++
 rtl/pixel_stream_receiver.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pixel_stream_pkg.sv
// rtl/pixel_stream_pkg.sv - shared types and constants for the pixel stream receiver
package pixel_stream_pkg;

    localparam int DEF_DATA_WIDTH = 10;
    localparam int DEF_RGB_SIZE   = 24;

    // Bit positions inside err_o
    localparam int ERR_EARLY_SOF  = 2;
    localparam int ERR_BAD_LAST_X = 1;
    localparam int ERR_BAD_LAST_Y = 0;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        IN_FRAME = 1'b1
    } rx_state_t;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] x;
        logic [DEF_DATA_WIDTH-1:0] y;
        logic [DEF_RGB_SIZE-1:0]   colour;
    } pixel_beat_t;

endpackage

// File: rtl/pixel_stream_receiver_skid.sv
// rtl/pixel_stream_receiver_skid.sv - 2-entry valid/ready register pair (pixel_skid_buffer)
// Ports:
//   clk, reset_n               clock, synchronous active-low reset
//   s_tvalid/s_tdata/s_tready  write side; s_tready is registered (1 iff < 2 entries held)
//   m_tvalid/m_tdata/m_tready  read side; m_tdata is the oldest entry, stable until popped
module pixel_skid_buffer
    import pixel_stream_pkg::*;
#(
    parameter type beat_t = pixel_beat_t
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  s_tvalid,
    input  beat_t s_tdata,
    output logic  s_tready,
    output logic  m_tvalid,
    input  logic  m_tready,
    output beat_t m_tdata
);

    logic [1:0] count;
    logic [1:0] count_next;
    beat_t      slot0;
    beat_t      slot1;
    logic       push;
    logic       pop;

    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;
    assign m_tvalid = (count != 2'd0);
    assign m_tdata  = slot0;

    always_comb begin
        count_next = count + {1'b0, push} - {1'b0, pop};
    end

    // slot0 is always the head; a pop shifts slot1 forward so ordering is kept.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count    <= 2'd0;
            s_tready <= 1'b0;
            slot0    <= '0;
            slot1    <= '0;
        end else begin
            count    <= count_next;
            s_tready <= (count_next != 2'd2);
            if (push && !pop) begin
                if (count == 2'd0) slot0 <= s_tdata;
                else               slot1 <= s_tdata;
            end else if (!push && pop) begin
                slot0 <= slot1;
            end else if (push && pop) begin
                if (count == 2'd1) begin
                    slot0 <= s_tdata;
                end else begin
                    slot0 <= slot1;
                    slot1 <= s_tdata;
                end
            end
        end
    end

endmodule

// File: rtl/pixel_stream_receiver.sv
// rtl/pixel_stream_receiver.sv - pixel stream sink: coordinate rebuild, framing check, skid output
// Ports:
//   clk, reset_n                                   clock, synchronous active-low reset
//   colour_i, first_i, last_x_i, last_y_i          incoming beat and framing flags
//   valid_i / ready_o                              upstream handshake
//   pix_x_o, pix_y_o, colour_o                     outgoing pixel
//   pix_valid_o / pix_ready_i                      downstream handshake
//   frame_done_o                                   1-cycle pulse per completed frame
//   err_o, err_clr_i                               sticky {early_sof, bad_last_x, bad_last_y}
//   drop_count_o                                   saturating count of beats dropped hunting SOF
module pixel_stream_receiver
    import pixel_stream_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int RGB_SIZE      = DEF_RGB_SIZE,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [RGB_SIZE-1:0]   colour_i,
    input  logic                  first_i,
    input  logic                  last_x_i,
    input  logic                  last_y_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] pix_x_o,
    output logic [DATA_WIDTH-1:0] pix_y_o,
    output logic [RGB_SIZE-1:0]   colour_o,
    output logic                  pix_valid_o,
    input  logic                  pix_ready_i,
    output logic                  frame_done_o,
    output logic [2:0]            err_o,
    input  logic                  err_clr_i,
    output logic [15:0]           drop_count_o
);

    localparam logic [DATA_WIDTH-1:0] X_LAST = DATA_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] Y_LAST = DATA_WIDTH'(SCREEN_HEIGHT - 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] x;
        logic [DATA_WIDTH-1:0] y;
        logic [RGB_SIZE-1:0]   colour;
    } beat_t;

    rx_state_t             state, state_n;
    logic [DATA_WIDTH-1:0] ex, ey, ex_n, ey_n;
    logic [DATA_WIDTH-1:0] cx, cy;
    logic                  line_end, last_row, bad_x, bad_y;
    logic                  accept, push, drop_inc, done_n;
    logic [2:0]            err_set;
    beat_t                 push_beat;
    beat_t                 out_beat;

    assign accept = valid_i && ready_o;

    always_comb begin
        state_n   = state;
        ex_n      = ex;
        ey_n      = ey;
        push      = 1'b0;
        drop_inc  = 1'b0;
        done_n    = 1'b0;
        err_set   = 3'b000;
        // A start-of-frame beat is always position (0,0), whatever was expected.
        cx        = first_i ? '0 : ex;
        cy        = first_i ? '0 : ey;
        line_end  = (cx == X_LAST);
        last_row  = (cy == Y_LAST);
        bad_x     = (last_x_i != line_end);
        bad_y     = (last_y_i != last_row);
        push_beat = '{x: cx, y: cy, colour: colour_i};

        if (accept) begin
            if (state == WAIT_SOF && !first_i) begin
                drop_inc = 1'b1;
            end else if (state == IN_FRAME && !first_i && (bad_x || bad_y)) begin
                err_set[ERR_BAD_LAST_X] = bad_x;
                err_set[ERR_BAD_LAST_Y] = bad_y;
                state_n                 = WAIT_SOF;
            end else begin
                if (state == IN_FRAME && first_i) err_set[ERR_EARLY_SOF] = 1'b1;
                push = 1'b1;
                if (line_end && last_row) begin
                    done_n  = 1'b1;
                    state_n = WAIT_SOF;
                    ex_n    = '0;
                    ey_n    = '0;
                end else if (line_end) begin
                    state_n = IN_FRAME;
                    ex_n    = '0;
                    ey_n    = cy + DATA_WIDTH'(1);
                end else begin
                    state_n = IN_FRAME;
                    ex_n    = cx + DATA_WIDTH'(1);
                    ey_n    = cy;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= WAIT_SOF;
            ex           <= '0;
            ey           <= '0;
            frame_done_o <= 1'b0;
            err_o        <= 3'b000;
            drop_count_o <= 16'h0000;
        end else begin
            state        <= state_n;
            ex           <= ex_n;
            ey           <= ey_n;
            frame_done_o <= done_n;
            // A new error in the clearing cycle survives the clear.
            err_o        <= (err_clr_i ? 3'b000 : err_o) | err_set;
            if (drop_inc && drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 16'd1;
        end
    end

    pixel_skid_buffer #(
        .beat_t (beat_t)
    ) u_skid (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_tvalid (push),
        .s_tdata  (push_beat),
        .s_tready (ready_o),
        .m_tvalid (pix_valid_o),
        .m_tready (pix_ready_i),
        .m_tdata  (out_beat)
    );

    assign pix_x_o  = out_beat.x;
    assign pix_y_o  = out_beat.y;
    assign colour_o = out_beat.colour;

endmodule
